// File: rtl/gpio_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : gpio_edge_sync
// Purpose  : Per-channel GPIO input conditioning. Each channel is synchronised,
//            debounced, and turned into an edge/level event with sticky status
//            and a combined interrupt.
// Ports    : des_clk    - sole clock, rising edge
//            des_rst    - synchronous active-high reset
//            i_sig      - asynchronous GPIO inputs, one bit per channel
//            cfg_mode   - 2 bits per channel: 00 rise, 01 fall, 10 both, 11 level
//            cfg_db_len - shared debounce length in cycles (0/1 = bypass)
//            int_en     - per-channel interrupt enable
//            int_clr    - per-channel sticky status clear
//            o_lvl      - debounced synchronised level
//            o_sig      - registered event (pulse in edge modes, level in 11)
//            o_stat     - sticky event status
//            o_irq      - registered OR of (o_stat & int_en)
// Revision : 1.0 - initial release
// ============================================================================
module gpio_edge_sync #(
    parameter int CH       = 8,
    parameter int SYNC_STG = 2,
    parameter int DB_W     = 8
) (
    input  logic                des_clk,
    input  logic                des_rst,
    input  logic [CH-1:0]       i_sig,
    input  logic [2*CH-1:0]     cfg_mode,
    input  logic [DB_W-1:0]     cfg_db_len,
    input  logic [CH-1:0]       int_en,
    input  logic [CH-1:0]       int_clr,
    output logic [CH-1:0]       o_lvl,
    output logic [CH-1:0]       o_sig,
    output logic [CH-1:0]       o_stat,
    output logic                o_irq
);

    localparam logic [1:0]      c_mode_rise = 2'b00;
    localparam logic [1:0]      c_mode_fall = 2'b01;
    localparam logic [1:0]      c_mode_both = 2'b10;
    localparam int              c_warm_w    = $clog2(SYNC_STG + 2);
    localparam logic [c_warm_w-1:0] c_warm_len = c_warm_w'(SYNC_STG + 1);
    localparam logic [DB_W-1:0] c_cnt_max   = '1;

    logic [CH-1:0]         r_sync_q [SYNC_STG];
    logic [CH-1:0]         r_lvl_q;
    logic [CH-1:0]         r_prev_q;
    logic [CH-1:0]         r_sig_q;
    logic [CH-1:0]         r_stat_q;
    logic                  r_irq_q;
    logic [c_warm_w-1:0]   r_warm_q;

    logic [CH-1:0]         w_s;
    logic [CH-1:0]         w_lvl_d;
    logic [CH-1:0]         w_evt;
    logic                  w_warm;
    logic                  w_bypass;
    logic [DB_W-1:0]       w_db_lim;

    assign w_s      = r_sync_q[SYNC_STG-1];
    // Warm-up lasts SYNC_STG+1 cycles so the synchroniser has flushed its
    // reset zeros into o_lvl/d_prev before any event can be generated.
    assign w_warm   = (r_warm_q != c_warm_len);
    assign w_bypass = (cfg_db_len <= DB_W'(1));
    assign w_db_lim = cfg_db_len - DB_W'(1);

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    always_ff @(posedge des_clk) begin
        if (des_rst) begin
            for (int k = 0; k < SYNC_STG; k++) begin
                r_sync_q[k] <= '0;
            end
        end else begin
            r_sync_q[0] <= i_sig;
            for (int k = 1; k < SYNC_STG; k++) begin
                r_sync_q[k] <= r_sync_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce and event decode
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [DB_W-1:0] r_cnt_q;
        logic [DB_W-1:0] w_cnt_d;
        logic            w_mis;
        logic            w_load;
        logic            w_evt_raw;

        assign w_mis  = w_s[i] ^ r_lvl_q[i];
        // ">=" rather than "==" so that shrinking cfg_db_len below the
        // current count commits the pending mismatch on the next edge.
        assign w_load = w_warm | w_bypass | (w_mis & (r_cnt_q >= w_db_lim));
        assign w_lvl_d[i] = w_load ? w_s[i] : r_lvl_q[i];

        always_comb begin
            w_cnt_d = '0;
            if (!w_load && w_mis) begin
                w_cnt_d = (r_cnt_q == c_cnt_max) ? r_cnt_q : r_cnt_q + DB_W'(1);
            end
        end

        always_ff @(posedge des_clk) begin
            if (des_rst) begin
                r_cnt_q <= '0;
            end else begin
                r_cnt_q <= w_cnt_d;
            end
        end

        always_comb begin
            w_evt_raw = 1'b0;
            case (cfg_mode[2*i +: 2])
                c_mode_rise: w_evt_raw = r_lvl_q[i] & ~r_prev_q[i];
                c_mode_fall: w_evt_raw = ~r_lvl_q[i] & r_prev_q[i];
                c_mode_both: w_evt_raw = r_lvl_q[i] ^ r_prev_q[i];
                default:     w_evt_raw = r_lvl_q[i];
            endcase
        end

        assign w_evt[i] = w_evt_raw & ~w_warm;
    end

    // ------------------------------------------------------------------
    // Level, event, status and interrupt registers
    // ------------------------------------------------------------------
    always_ff @(posedge des_clk) begin
        if (des_rst) begin
            r_lvl_q  <= '0;
            r_prev_q <= '0;
            r_sig_q  <= '0;
            r_stat_q <= '0;
            r_irq_q  <= 1'b0;
            r_warm_q <= '0;
        end else begin
            r_lvl_q  <= w_lvl_d;
            r_prev_q <= w_warm ? w_s : r_lvl_q;
            r_sig_q  <= w_evt;
            // Set has priority over a coincident clear.
            r_stat_q <= (r_stat_q & ~int_clr) | w_evt;
            r_irq_q  <= |(r_stat_q & int_en);
            if (w_warm) begin
                r_warm_q <= r_warm_q + c_warm_w'(1);
            end
        end
    end

    assign o_lvl  = r_lvl_q;
    assign o_sig  = r_sig_q;
    assign o_stat = r_stat_q;
    assign o_irq  = r_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_edge_sync
// Purpose  : Self-checking bench for gpio_edge_sync. A driver applies inputs
//            on the falling edge and pushes the model's expected post-edge
//            outputs into a queue; a monitor pops and compares after each
//            rising edge. Directed checks cover the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_edge_sync;

    localparam int CH  = 8;
    localparam int SS  = 2;
    localparam int DBW = 8;

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] sig;
        logic [CH-1:0] stat;
        logic          irq;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   sig;
    logic [2*CH-1:0] mode;
    logic [DBW-1:0]  db;
    logic [CH-1:0]   en;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   o_lvl;
    logic [CH-1:0]   o_sig;
    logic [CH-1:0]   o_stat;
    logic            o_irq;

    always #5 clk = ~clk;

    gpio_edge_sync #(.CH(CH), .SYNC_STG(SS), .DB_W(DBW)) dut (
        .des_clk    (clk),
        .des_rst    (rst),
        .i_sig      (sig),
        .cfg_mode   (mode),
        .cfg_db_len (db),
        .int_en     (en),
        .int_clr    (clr),
        .o_lvl      (o_lvl),
        .o_sig      (o_sig),
        .o_stat     (o_stat),
        .o_irq      (o_irq)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: input history as a delay queue, debounce as the
    // length of the current mismatch run, events from level vs. previous.
    // ------------------------------------------------------------------
    logic [CH-1:0] m_hist[$];
    logic [CH-1:0] m_lvl, m_prev, m_sig, m_stat;
    logic          m_irq;
    int            m_run[CH];
    int            m_since_rst;

    task automatic step_model();
        logic [CH-1:0] s, evt, lvl_n;
        logic          a, b;
        bit            warmup;
        exp_t          e;
        if (rst) begin
            m_hist = {};
            repeat (SS) m_hist.push_back('0);
            m_lvl = '0; m_prev = '0; m_sig = '0; m_stat = '0; m_irq = 1'b0;
            foreach (m_run[c]) m_run[c] = 0;
            m_since_rst = 0;
        end else begin
            s = m_hist.pop_front();
            m_hist.push_back(sig);
            warmup = (m_since_rst < SS + 1);
            m_since_rst++;
            for (int c = 0; c < CH; c++) begin
                a = m_lvl[c];
                b = m_prev[c];
                case (mode[2*c +: 2])
                    2'd0:    evt[c] = a && !b;
                    2'd1:    evt[c] = !a && b;
                    2'd2:    evt[c] = (a != b);
                    default: evt[c] = a;
                endcase
                if (warmup) evt[c] = 1'b0;
                lvl_n[c] = m_lvl[c];
                if (warmup || db <= 1) begin
                    lvl_n[c] = s[c];
                    m_run[c] = 0;
                end else if (s[c] == m_lvl[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] >= int'(db)) begin
                        lvl_n[c] = s[c];
                        m_run[c] = 0;
                    end
                end
            end
            m_irq  = |(m_stat & en);
            m_stat = (m_stat & ~clr) | evt;
            m_sig  = evt;
            m_prev = warmup ? s : m_lvl;
            m_lvl  = lvl_n;
        end
        e.lvl = m_lvl; e.sig = m_sig; e.stat = m_stat; e.irq = m_irq;
        exp_q.push_back(e);
    endtask

    // One clock: inputs are already set; model the coming edge, then wait.
    task automatic cyc();
        step_model();
        @(negedge clk);
    endtask

    // Monitor: compare after every rising edge that has an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scoreboard", {7'd0, o_lvl, o_sig, o_stat, o_irq}, {7'd0, e});
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    initial begin
        int          pulses;
        logic [CH-1:0] sig_or, stat_or;
        rst = 1'b1; sig = '0; mode = '0; db = '0; en = '0; clr = '0;
        @(negedge clk);

        // Reset state
        do_reset(3);
        chk("reset_stat", {24'd0, o_stat}, 32'd0);
        chk("reset_irq", {31'd0, o_irq}, 32'd0);
        repeat (4) cyc();

        // Bypass rising edge on ch0: pulse on edge SYNC_STG+2, irq one later
        en = 8'h01;
        sig[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("ch0_sig_e%0d", k), {31'd0, o_sig[0]}, {31'd0, k == 4});
            chk($sformatf("ch0_irq_e%0d", k), {31'd0, o_irq}, {31'd0, k >= 5});
        end
        chk("ch0_stat", {31'd0, o_stat[0]}, 32'd1);
        clr = '1; cyc(); clr = '0;

        // Debounce 5 on ch1: 4-cycle glitch rejected, 5-cycle run accepted
        db = 8'd5;
        pulses = 0;
        sig[1] = 1'b1; repeat (4) begin cyc(); pulses += o_sig[1]; end
        sig[1] = 1'b0; repeat (8) begin cyc(); pulses += o_sig[1]; end
        chk("ch1_glitch_lvl", {31'd0, o_lvl[1]}, 32'd0);
        sig[1] = 1'b1; repeat (12) begin cyc(); pulses += o_sig[1]; end
        chk("ch1_lvl", {31'd0, o_lvl[1]}, 32'd1);
        chk("ch1_pulses", pulses, 32'd1);

        // Both-edges on ch2, toggling every 20 cycles, clear held high
        db = 8'd0;
        mode[5:4] = 2'b10;
        clr[2] = 1'b1;
        pulses = 0;
        for (int t = 0; t < 4; t++) begin
            sig[2] = ~sig[2];
            repeat (20) begin cyc(); pulses += o_sig[2]; end
        end
        chk("ch2_pulses", pulses, 32'd4);
        clr = '0;

        // Static-high inputs through reset release: no spurious events
        sig = '1;
        mode = 16'b10_01_00_10_01_00_10_01;
        do_reset(2);
        sig_or = '0; stat_or = '0;
        repeat (10) begin cyc(); sig_or |= o_sig; stat_or |= o_stat; end
        chk("static_lvl", {24'd0, o_lvl}, 32'hFF);
        chk("static_sig", {24'd0, sig_or}, 32'd0);
        chk("static_stat", {24'd0, stat_or}, 32'd0);

        // Randomised run
        for (int n = 0; n < 2000; n++) begin
            if (n % 97 == 0) begin
                case ($urandom_range(0, 5))
                    0: db = 8'd0;
                    1: db = 8'd1;
                    2: db = 8'd2;
                    3: db = 8'd3;
                    4: db = 8'd5;
                    default: db = 8'd8;
                endcase
            end
            if (n % 211 == 0) mode = 16'($urandom);
            if (n % 53 == 0)  en = 8'($urandom);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) sig[c] = ~sig[c];
            end
            clr = 8'($urandom) & 8'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst = 1'b0; clr = '0;

        // All channels rise together, then reset mid-debounce
        sig = '0; mode = '0; db = 8'd0;
        do_reset(2);
        repeat (5) cyc();
        sig = '1;
        repeat (3) cyc();
        cyc();
        chk("all_rise_sig", {24'd0, o_sig}, 32'hFF);
        cyc();
        chk("all_rise_sig_off", {24'd0, o_sig}, 32'd0);
        db = 8'd200;
        en = '1;
        sig = '0;
        repeat (10) cyc();
        chk("mid_db_lvl", {24'd0, o_lvl}, 32'hFF);
        rst = 1'b1;
        cyc();
        chk("mid_db_reset", {7'd0, o_lvl, o_sig, o_stat, o_irq}, 32'd0);
        rst = 1'b0;
        repeat (6) cyc();

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_edge_sync.md
GPIO_EDGE_SYNC -- requirements
Module: gpio_edge_sync

Parameters
REQ-001 SHALL provide CH, default 8, number of independent input channels (1..32).
REQ-002 SHALL provide SYNC_STG, default 2, synchroniser depth in flops (2..4).
REQ-003 SHALL provide DB_W, default 8, debounce counter width in bits (1..16).

Interface
REQ-004 SHALL have des_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have des_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have i_sig  input  CH  asynchronous GPIO inputs, one bit per channel.
REQ-007 SHALL have cfg_mode  input  2*CH  per-channel mode in bits [2i+1:2i]: 00 rising, 01 falling, 10 both edges, 11 level-high.
REQ-008 SHALL have cfg_db_len  input  DB_W  debounce length in cycles, shared by all channels; 0 and 1 both mean bypass.
REQ-009 SHALL have int_en  input  CH  per-channel interrupt enable.
REQ-010 SHALL have int_clr  input  CH  per-channel status clear, sampled each cycle.
REQ-011 SHALL have o_lvl  output  CH  debounced, synchronised level.
REQ-012 SHALL have o_sig  output  CH  registered per-channel event: a one-cycle pulse in edge modes, the held level in level mode.
REQ-013 SHALL have o_stat  output  CH  sticky event status.
REQ-014 SHALL have o_irq  output  1  registered OR over all channels of (o_stat & int_en).

Function
REQ-015 SHALL pass each i_sig bit through a SYNC_STG-deep flop chain; the last stage is s[i].
REQ-016 SHALL keep a per-channel debounce counter cnt[i]:
- cleared whenever s[i]==o_lvl[i];
- otherwise incremented;
- when it reaches cfg_db_len-1 while s[i]!=o_lvl[i], o_lvl[i] is loaded with s[i] and cnt[i] is cleared.
REQ-017 SHALL, with cfg_db_len of 0 or 1, load o_lvl[i] from s[i] every cycle.
REQ-018 SHALL discard any mismatch run shorter than cfg_db_len cycles: o_lvl stays unchanged and cnt returns to 0.
REQ-019 SHALL register d_prev[i] <= o_lvl[i] and derive the event from o_lvl and d_prev as follows:
- rising: o_lvl & ~d_prev;
- falling: ~o_lvl & d_prev;
- both: o_lvl ^ d_prev;
- level: o_lvl.
REQ-020 SHALL register o_sig[i] <= event[i] and update o_stat[i] <= (o_stat[i] & ~int_clr[i]) | event[i]; when set and clear coincide, set wins.
REQ-021 SHALL give o_irq one cycle of latency after o_stat.
REQ-022 SHALL, with bypass debounce, produce o_sig high on the (SYNC_STG+2)th rising edge after the first edge that samples the new i_sig value; in edge modes it stays high exactly one cycle.
REQ-023 SHALL apply cfg_mode changes from the next cycle without generating an event by themselves; a channel switched into level mode while o_lvl=1 asserts o_sig and sets o_stat.
REQ-024 SHALL apply cfg_db_len changes immediately; if cnt[i] is already at or above the new cfg_db_len-1 and a mismatch persists, o_lvl updates on the next edge.
REQ-025 SHALL saturate cnt at 2^DB_W-1 and never wrap.
REQ-026 SHALL treat every channel independently; simultaneous events on any number of channels are all captured in the same cycle.

Reset
REQ-027 SHALL, while des_rst=1, force synchroniser flops, cnt, o_lvl, d_prev, o_sig, o_stat and o_irq to 0.
REQ-028 SHALL run a warm-up counter for SYNC_STG+1 cycles after des_rst deasserts; during warm-up o_lvl and d_prev load s each cycle and all events are suppressed.
REQ-029 SHALL not raise a spurious event when an input is static high across reset release; o_lvl=1 after warm-up and o_sig/o_stat stay 0 in edge modes.
REQ-030 SHALL, when des_rst is asserted mid-debounce or mid-pulse, return everything to reset values on that edge and lose pending events.

Verification
REQ-031 SHALL cover: CH=8, SYNC_STG=2, db_len=0, mode 00 on ch0, i_sig[0] 0->1 -> o_sig[0] high 1 cycle on edge 4; o_stat[0]=1; o_irq=1 one cycle later when int_en[0]=1.
REQ-032 SHALL cover: db_len=5, ch1 glitch high for 4 cycles, then high for 5 cycles -> no event for the glitch; o_lvl[1] rises after the 5th stable cycle; one o_sig[1] pulse.
REQ-033 SHALL cover: mode 10 on ch2, a toggle every 20 cycles -> one o_sig[2] pulse per toggle; int_clr[2] coinciding with an event leaves o_stat[2]=1.
REQ-034 SHALL cover: i_sig=8'hFF held through reset release -> o_lvl=8'hFF after warm-up; o_sig=0 and o_stat=0 in modes 00/01/10.
REQ-035 SHALL cover: all 8 channels rising in the same cycle, mode 00 -> o_sig=8'hFF for exactly one cycle; then reset mid-debounce with db_len=200 -> all outputs 0 on the next edge.
